// File: rtl/dvp_tx_pkg.sv
// Shared types for the DVP test-pattern transmitter: FSM states, pattern codes
// and the colour-bar palette.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } dvp_state_t;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;
  localparam logic [1:0] PAT_DIAG  = 2'd3;

  // RGB565 bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/dvp_pixel_gen.sv
// Combinational RGB565 pixel generator: pixel = f(pattern, x, y, solid colour).
module dvp_pixel_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  pattern,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] solid_color,
  output logic [15:0] pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_sel;

  always_comb begin
    bar_sel = 3'(x / 16'(BAR_W));
    case (pattern)
      PAT_SOLID: pixel = solid_color;
      PAT_BARS:  pixel = bar_color(bar_sel);
      PAT_RAMP:  pixel = x;
      default:   pixel = x + y;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP transmitter: vsync/href/byte stream of RGB565 test patterns,
// high byte first, generated in the pclk domain.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | waiting for i_enable, all outputs low
//   ST_VSYNC  | vsync high for VSYNC_LINES lines
//   ST_VBP    | back porch, VBP_LINES lines of blanking
//   ST_ACTIVE | V_ACTIVE lines, href high over the active bytes
//   ST_VFP    | front porch, eof on its last cycle
module dvp_pattern_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_solid_color,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam int LINE_BYTES = 2 * (H_ACTIVE + H_BLANK);
  localparam int HW         = $clog2(LINE_BYTES);

  dvp_state_t    state, nxt_state;
  logic [HW-1:0] hcnt, nxt_hcnt;
  logic [15:0]   vcnt, nxt_vcnt, state_lines;
  logic          start, href_n, eof_n;
  logic [1:0]    pat_q;
  logic [15:0]   color_q, pixel;

  // Outputs are registered from the next-cycle counters so they line up with state.
  always_comb begin
    nxt_state = state;
    nxt_hcnt  = hcnt;
    nxt_vcnt  = vcnt;
    start     = 1'b0;
    case (state)
      ST_VSYNC:  state_lines = 16'(VSYNC_LINES);
      ST_VBP:    state_lines = 16'(VBP_LINES);
      ST_ACTIVE: state_lines = 16'(V_ACTIVE);
      ST_VFP:    state_lines = 16'(VFP_LINES);
      default:   state_lines = 16'd1;
    endcase
    if (state == ST_IDLE) begin
      if (i_enable) begin
        nxt_state = ST_VSYNC;
        nxt_hcnt  = '0;
        nxt_vcnt  = '0;
        start     = 1'b1;
      end
    end else if (hcnt == HW'(LINE_BYTES - 1)) begin
      nxt_hcnt = '0;
      if (vcnt == state_lines - 16'd1) begin
        nxt_vcnt = '0;
        case (state)
          ST_VSYNC:  nxt_state = ST_VBP;
          ST_VBP:    nxt_state = ST_ACTIVE;
          ST_ACTIVE: nxt_state = ST_VFP;
          default: begin
            nxt_state = i_enable ? ST_VSYNC : ST_IDLE;
            start     = i_enable;
          end
        endcase
      end else begin
        nxt_vcnt = vcnt + 16'd1;
      end
    end else begin
      nxt_hcnt = hcnt + HW'(1);
    end
    href_n = (nxt_state == ST_ACTIVE) && (nxt_hcnt < HW'(2 * H_ACTIVE));
    eof_n  = (nxt_state == ST_VFP) && (nxt_hcnt == HW'(LINE_BYTES - 1)) &&
             (nxt_vcnt == 16'(VFP_LINES - 1));
  end

  dvp_pixel_gen #(.H_ACTIVE(H_ACTIVE)) u_pixel_gen (
    .pattern     (pat_q),
    .x           (16'(nxt_hcnt[HW-1:1])),
    .y           (nxt_vcnt),
    .solid_color (color_q),
    .pixel       (pixel)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      pat_q       <= '0;
      color_q     <= '0;
      o_vsync     <= 1'b0;
      o_href      <= 1'b0;
      o_data      <= 8'h00;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_cnt <= 16'd0;
    end else begin
      state <= nxt_state;
      hcnt  <= nxt_hcnt;
      vcnt  <= nxt_vcnt;
      if (start) begin
        pat_q   <= i_pattern;
        color_q <= i_solid_color;
      end
      o_vsync <= (nxt_state == ST_VSYNC);
      o_href  <= href_n;
      o_data  <= href_n ? (nxt_hcnt[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
      o_sof   <= start;
      o_eof   <= eof_n;
      o_busy  <= (nxt_state != ST_IDLE);
      if (eof_n) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx on a tiny 8x3 frame, checked against a frame-position
// reference model.
module tb_dvp_pattern_tx;

  localparam int HA = 8, HB = 2, VA = 3, VS = 1, VBP = 1, VFP = 1;
  localparam int LB = 2 * (HA + HB);
  localparam int FRAME = LB * (VS + VBP + VA + VFP);

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [1:0]  i_pattern = 2'd0;
  logic [15:0] i_solid_color = 16'h0000;
  logic        o_vsync, o_href, o_sof, o_eof, o_busy;
  logic [7:0]  o_data;
  logic [15:0] o_frame_cnt;

  int passed = 0;
  int total  = 0;

  // model: position within the frame (-1 = idle), latched pattern, frame counter
  int          mpos = -1;
  logic [1:0]  m_pat = 2'd0;
  logic [15:0] m_col = 16'h0000;
  logic [15:0] m_fcnt = 16'd0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0]  bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  logic [28:0] dut_vec;
  assign dut_vec = {o_vsync, o_href, o_data, o_sof, o_eof, o_busy, o_frame_cnt};

  dvp_pattern_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_pattern     (i_pattern),
    .i_solid_color (i_solid_color),
    .o_vsync       (o_vsync),
    .o_href        (o_href),
    .o_data        (o_data),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_busy        (o_busy),
    .o_frame_cnt   (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  // Advance the model with the inputs about to be sampled, then move past the edge.
  task automatic tick();
    if (i_rst) begin
      mpos   = -1;
      m_fcnt = 16'd0;
    end else if (mpos < 0 || mpos == FRAME - 1) begin
      if (i_enable) begin
        mpos  = 0;
        m_pat = i_pattern;
        m_col = i_solid_color;
      end else begin
        mpos = -1;
      end
    end else begin
      mpos++;
    end
    if (!i_rst && mpos == FRAME - 1) m_fcnt = m_fcnt + 16'd1;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [28:0] exp_vec();
    int line, h, x, y;
    logic vs, hr;
    logic [15:0] px;
    logic [7:0] d;
    vs = 1'b0; hr = 1'b0; d = 8'h00; px = 16'h0000;
    if (mpos >= 0) begin
      line = mpos / LB;
      h    = mpos % LB;
      vs   = (line < VS);
      if (line >= VS + VBP && line < VS + VBP + VA && h < 2 * HA) begin
        hr = 1'b1;
        x  = h / 2;
        y  = line - VS - VBP;
        case (m_pat)
          2'd0:    px = m_col;
          2'd1:    px = bars[x / (HA / 8)];
          2'd2:    px = 16'(x);
          default: px = 16'(x + y);
        endcase
        d = (h % 2 == 0) ? px[15:8] : px[7:0];
      end
    end
    return {vs, hr, d, mpos == 0, mpos == FRAME - 1, mpos >= 0, m_fcnt};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      total++;
      if (dut_vec !== 29'd0 || dut_vec !== exp_vec())
        $display("FAIL reset c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
    end
    i_rst = 1'b0;
  endtask

  task automatic test_solid();
    int vs_cnt = 0, hr_cnt = 0, eof_at = -1;
    i_pattern = 2'd0; i_solid_color = 16'hF81F; i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    i_solid_color = 16'($urandom);
    for (int c = 1; c <= 130; c++) begin
      total++;
      if (dut_vec !== exp_vec())
        $display("FAIL solid c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
      if (o_vsync) vs_cnt++;
      if (o_href) hr_cnt++;
      if (o_eof) eof_at = c;
      tick();
    end
    total++;
    if (vs_cnt !== 20) $display("FAIL solid_vsync_len: got %0d, required 20", vs_cnt); else passed++;
    total++;
    if (hr_cnt !== 48) $display("FAIL solid_href_len: got %0d, required 48", hr_cnt); else passed++;
    total++;
    if (eof_at !== 120) $display("FAIL solid_eof_cycle: got %0d, required 120", eof_at); else passed++;
    total++;
    if (o_frame_cnt !== 16'd1 || o_busy !== 1'b0)
      $display("FAIL solid_end: frame_cnt %0d busy %b, required 1 and 0", o_frame_cnt, o_busy);
    else passed++;
  endtask

  task automatic test_bars();
    logic [7:0] q[$];
    i_pattern = 2'd1; i_solid_color = 16'($urandom); i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      total++;
      if (dut_vec !== exp_vec())
        $display("FAIL bars c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
      if (o_href) q.push_back(o_data);
      i_pattern = 2'($urandom_range(0, 3));
      tick();
    end
    total++;
    if (q.size() !== 48) $display("FAIL bars_count: got %0d, required 48", q.size()); else passed++;
    for (int i = 0; i < q.size() && i < 48; i++) begin
      total++;
      if (q[i] !== bar_bytes[i % 16])
        $display("FAIL bars_byte%0d: got %h, required %h", i, q[i], bar_bytes[i % 16]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fc[$];
    int hidx = 0, nsof = 0;
    logic [7:0] b46 = 8'hxx, b47 = 8'hxx;
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    i_pattern = 2'd3; i_enable = 1'b1;
    tick();
    for (int c = 1; c <= 380; c++) begin
      total++;
      if (dut_vec !== exp_vec())
        $display("FAIL b2b c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
      if (o_sof) begin nsof++; hidx = 0; end
      if (o_href) begin
        if (nsof == 1 && hidx == 46) b46 = o_data;
        if (nsof == 1 && hidx == 47) b47 = o_data;
        hidx++;
      end
      if (o_eof) fc.push_back(o_frame_cnt);
      if (c == 300) i_enable = 1'b0;
      tick();
    end
    total++;
    if (b46 !== 8'h00 || b47 !== 8'h09)
      $display("FAIL diag_x7y2: got %h,%h, required 00,09", b46, b47);
    else passed++;
    total++;
    if (fc.size() !== 3 || fc[0] !== 16'd1 || fc[1] !== 16'd2 || fc[2] !== 16'd3)
      $display("FAIL b2b_frame_cnt: got %0d frames, last %0d, required 3 frames 1,2,3",
               fc.size(), o_frame_cnt);
    else passed++;
  endtask

  task automatic test_enable_drop();
    int drop_at = $urandom_range(41, 100);
    i_pattern = 2'($urandom_range(0, 3)); i_solid_color = 16'($urandom); i_enable = 1'b1;
    tick();
    for (int c = 1; c <= 140; c++) begin
      total++;
      if (dut_vec !== exp_vec())
        $display("FAIL en_drop c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
      if (c == drop_at) i_enable = 1'b0;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int rst_at = $urandom_range(41, 100);
    i_pattern = 2'd2; i_enable = 1'b1;
    tick();
    for (int c = 1; c < rst_at; c++) tick();
    i_rst = 1'b1;
    tick();
    total++;
    if (dut_vec !== 29'd0)
      $display("FAIL mid_reset_outputs: got %h, required 0", dut_vec);
    else passed++;
    i_rst = 1'b0; i_enable = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    i_pattern = 2'($urandom_range(0, 3)); i_solid_color = 16'($urandom); i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      total++;
      if (dut_vec !== exp_vec())
        $display("FAIL mid_reset c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
      tick();
    end
    total++;
    if (o_frame_cnt !== 16'd1)
      $display("FAIL mid_reset_frame_cnt: got %0d, required 1", o_frame_cnt);
    else passed++;
  endtask

  task automatic test_pattern_change();
    logic [7:0] q[$];
    int nsof = 0;
    i_pattern = 2'd0; i_solid_color = 16'($urandom); i_enable = 1'b1;
    tick();
    for (int c = 1; c <= 260; c++) begin
      total++;
      if (dut_vec !== exp_vec())
        $display("FAIL pat_change c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
      if (o_sof) nsof++;
      if (nsof == 2 && o_href) q.push_back(o_data);
      if (c == 60) begin i_pattern = 2'd2; i_solid_color = 16'($urandom); end
      if (c == 150) i_enable = 1'b0;
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q.size() < 16 || q[i] !== ((i % 2 == 1) ? 8'(i / 2) : 8'h00))
        $display("FAIL ramp_byte%0d: got %h, required %h", i,
                 (q.size() > i) ? q[i] : 8'hxx, (i % 2 == 1) ? 8'(i / 2) : 8'h00);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      i_enable      = ($urandom_range(0, 9) < 3);
      i_pattern     = 2'($urandom_range(0, 3));
      i_solid_color = 16'($urandom);
      i_rst         = ($urandom_range(0, 299) == 0);
      tick();
      total++;
      if (dut_vec !== exp_vec())
        $display("FAIL random c%0d: got %h, required %h", c, dut_vec, exp_vec());
      else passed++;
    end
    i_rst = 1'b0; i_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_solid();
    test_bars();
    test_back_to_back();
    test_enable_drop();
    test_mid_reset();
    test_pattern_change();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
